// File: rtl/mult_char_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_char_pkg                                                |
// | Description : Shared widths, LFSR taps, FSM states and delay-line slot     |
// |               type for the multiplier characterization stimulus/checker.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mult_char_pkg;

  localparam int A_W   = 20;  // operand A width
  localparam int B_W   = 18;  // operand B width
  localparam int Z_W   = 38;  // full product width (A_W + B_W)
  localparam int IDX_W = 16;  // vector index / counter width

  // Second tap of each Fibonacci LFSR (the first tap is always the MSB)
  localparam int A_TAP = 17;
  localparam int B_TAP = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // One entry of the expected-product delay line
  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
    logic [Z_W-1:0]   z;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/mult_char_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_char_lfsr                                               |
// | Description : Fibonacci LFSR, taps WIDTH and TAP, shifting toward the MSB  |
// |               with the feedback bit entering at bit 0.                     |
// | Ports       : clk     - clock                                              |
// |               reset   - asynchronous active-low reset (reloads the seed)   |
// |               load_i  - reload the seed (wins over step_i)                 |
// |               step_i  - advance one state                                  |
// |               state_o - current LFSR state                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mult_char_lfsr #(
  parameter int               WIDTH = 20,
  parameter int               TAP   = 17,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  // An all-zero state would lock the LFSR up, so a zero seed becomes 1
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             w_fb;

  assign w_fb = state_q[WIDTH-1] ^ state_q[TAP-1];

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = SEED_EFF;
    end else if (step_i) begin
      state_d = {state_q[WIDTH-2:0], w_fb};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED_EFF;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/mult_char_stim_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_char_stim_check                                         |
// | Description : Drives pseudo-random operands into a multiplier under test,  |
// |               predicts each product through a latency-matched delay line,  |
// |               compares the returned product and reports pass/fail.         |
// | Ports       : clk            - clock                                       |
// |               reset          - asynchronous active-low reset               |
// |               start          - run request (honoured in IDLE/DONE only)    |
// |               a_out, b_out   - operands to the multiplier under test       |
// |               z_in           - product from the multiplier under test      |
// |               busy, done     - run in progress / run complete              |
// |               pass           - done with no mismatches                     |
// |               error_count    - saturating mismatch count                   |
// |               first_fail_idx - index of first mismatch (FFFF if none)      |
// |               first_fail_z   - z_in captured at the first mismatch         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mult_char_stim_check
  import mult_char_pkg::*;
#(
  parameter int             LATENCY     = 2,
  parameter int             NUM_VECTORS = 1024,
  parameter logic [A_W-1:0] SEED_A      = 20'h00001,
  parameter logic [B_W-1:0] SEED_B      = 18'h00001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [A_W-1:0]   a_out,
  output logic [B_W-1:0]   b_out,
  input  logic [Z_W-1:0]   z_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] error_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [Z_W-1:0]   first_fail_z
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(LATENCY);
  localparam logic [IDX_W-1:0] NO_FAIL    = '1;
  localparam logic [IDX_W-1:0] ERR_MAX    = '1;

  state_e           state_q;
  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic [IDX_W-1:0] idx_q;        // index of the next vector to issue
  logic             issue_v_q;    // a_q/b_q were loaded with a new vector last edge
  logic [IDX_W-1:0] issue_idx_q;
  logic [3:0]       drain_q;
  slot_t            pipe_q [LATENCY];
  logic [IDX_W-1:0] err_q;
  logic [IDX_W-1:0] ffi_q;
  logic [Z_W-1:0]   ffz_q;
  logic             busy_q;
  logic             done_q;

  logic             w_run_start;
  logic             w_issue;
  logic [A_W-1:0]   w_lfsr_a;
  logic [B_W-1:0]   w_lfsr_b;
  logic [Z_W-1:0]   w_prod;
  logic             w_miss;

  assign w_run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign w_issue     = (state_q == ST_RUN);

  mult_char_lfsr #(
    .WIDTH (A_W),
    .TAP   (A_TAP),
    .SEED  (SEED_A)
  ) u_lfsr_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_run_start),
    .step_i  (w_issue),
    .state_o (w_lfsr_a)
  );

  mult_char_lfsr #(
    .WIDTH (B_W),
    .TAP   (B_TAP),
    .SEED  (SEED_B)
  ) u_lfsr_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_run_start),
    .step_i  (w_issue),
    .state_o (w_lfsr_b)
  );

  // Golden product of the operands currently on a_out/b_out. It enters the
  // delay line one edge after issue, so the slot reaches the tail on the same
  // edge the multiplier's LATENCY-th register presents the matching z_in.
  assign w_prod = Z_W'(a_q) * Z_W'(b_q);

  assign w_miss = pipe_q[LATENCY-1].v && (z_in != pipe_q[LATENCY-1].z);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      issue_v_q   <= 1'b0;
      issue_idx_q <= '0;
      drain_q     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      err_q       <= '0;
      ffi_q       <= NO_FAIL;
      ffz_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pipe_q[0] <= '{v: issue_v_q, idx: issue_idx_q, z: w_prod};
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      issue_v_q <= 1'b0;

      if (w_miss) begin
        if (err_q != ERR_MAX) begin
          err_q <= err_q + 16'd1;
        end
        if (ffi_q == NO_FAIL) begin
          ffi_q <= pipe_q[LATENCY-1].idx;
          ffz_q <= z_in;
        end
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            // Later assignments override the compare/shift updates above so
            // a fresh run always starts from a clean slate.
            state_q <= ST_RUN;
            idx_q   <= '0;
            err_q   <= '0;
            ffi_q   <= NO_FAIL;
            ffz_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
              pipe_q[i].v <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          a_q         <= w_lfsr_a;
          b_q         <= w_lfsr_b;
          issue_v_q   <= 1'b1;
          issue_idx_q <= idx_q;
          idx_q       <= idx_q + 16'd1;
          if (idx_q == LAST_IDX) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end
        end
        ST_DRAIN: begin
          // Exit on the edge that compares the last vector
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_out          = a_q;
  assign b_out          = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign error_count    = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_z   = ffz_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_char_stim_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mult_char_stim_check                                      |
// | Description : Self-checking bench: behavioural multiplier models feed two  |
// |               DUT instances; results are compared with a reference model   |
// |               built from the operand sequence and injected faults.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mult_char_stim_check;

  localparam int N0      = 1024;
  localparam int LAT     = 2;
  localparam int TIMEOUT = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic [19:0] a0, a1;
  logic [17:0] b0, b1;
  logic [37:0] z0, z1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] err0, ffi0, err1, ffi1;
  logic [37:0] ffz0, ffz1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_char_stim_check dut0 (
    .clk(clk), .reset(reset), .start(start0), .a_out(a0), .b_out(b0), .z_in(z0),
    .busy(busy0), .done(done0), .pass(pass0), .error_count(err0),
    .first_fail_idx(ffi0), .first_fail_z(ffz0)
  );

  mult_char_stim_check #(
    .LATENCY(2), .NUM_VECTORS(1), .SEED_A(20'hFFFFF), .SEED_B(18'h3FFFF)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a_out(a1), .b_out(b1), .z_in(z1),
    .busy(busy1), .done(done1), .pass(pass1), .error_count(err1),
    .first_fail_idx(ffi1), .first_fail_z(ffz1)
  );

  // ---------------- reference data ----------------
  logic [19:0] ref_a [N0];
  logic [17:0] ref_b [N0];
  logic [37:0] ref_p [N0];

  int          f_idx [$];   // faulted vector indices
  logic [37:0] f_msk [$];   // xor mask applied to the product of that vector
  int          m0_lat = LAT;
  logic [37:0] m1_mask = '0;

  function automatic logic [37:0] mask_of(input int k);
    for (int j = 0; j < f_idx.size(); j++)
      if (f_idx[j] == k) return f_msk[j];
    return '0;
  endfunction

  function automatic logic [37:0] op_mask(input logic [19:0] a, input logic [17:0] b);
    for (int j = 0; j < f_idx.size(); j++)
      if (ref_a[f_idx[j]] == a && ref_b[f_idx[j]] == b) return f_msk[j];
    return '0;
  endfunction

  // ---------------- multiplier models (registered, m0_lat stages) ----------------
  logic [37:0] m0_pipe [8];
  logic [37:0] m1_pipe [2];
  initial begin
    for (int i = 0; i < 8; i++) m0_pipe[i] = '0;
    m1_pipe[0] = '0;
    m1_pipe[1] = '0;
  end
  always @(posedge clk) begin
    m0_pipe[0] <= ({18'b0, a0} * {20'b0, b0}) ^ op_mask(a0, b0);
    for (int i = 1; i < 8; i++) m0_pipe[i] <= m0_pipe[i-1];
    m1_pipe[0] <= ({18'b0, a1} * {20'b0, b1}) ^ m1_mask;
    m1_pipe[1] <= m1_pipe[0];
  end
  assign z0 = m0_pipe[m0_lat-1];
  assign z1 = m1_pipe[1];

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset0(input string tag);
    chk({tag, "_a"}, a0, 0);
    chk({tag, "_b"}, b0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pass"}, pass0, 0);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_ffi"}, ffi0, 16'hFFFF);
    chk({tag, "_ffz"}, ffz0, 0);
  endtask

  // Expected outcome of one dut0 run. lat_extra=1 models a multiplier one
  // cycle slower than the checker expects; prev is the product the model
  // holds for the operands on the bus before the run.
  task automatic predict(input int lat_extra, input logic [37:0] prev,
                         output int e_err, output int e_ffi, output logic [37:0] e_ffz);
    logic [37:0] obs;
    e_err = 0;
    e_ffi = 16'hFFFF;
    e_ffz = '0;
    for (int k = 0; k < N0; k++) begin
      if (lat_extra == 0) obs = ref_p[k] ^ mask_of(k);
      else                obs = (k == 0) ? prev : (ref_p[k-1] ^ mask_of(k-1));
      if (obs != ref_p[k]) begin
        if (e_err < 65535) e_err++;
        if (e_ffi == 16'hFFFF) begin
          e_ffi = k;
          e_ffz = obs;
        end
      end
    end
  endtask

  // Pulse start, then count edges until done. p1/p2: extra start pulses
  // sampled at those edge numbers (0 = none).
  task automatic run(input bit sel, input int p1, input int p2, output int edges);
    bit pulse;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    chk(sel ? "d1_busy_after_start" : "d0_busy_after_start", sel ? busy1 : busy0, 1);
    edges = 0;
    while (!(sel ? done1 : done0) && edges < TIMEOUT) begin
      pulse = (p1 > 0 && edges == p1 - 1) || (p2 > 0 && edges == p2 - 1);
      if (sel) start1 = pulse; else start0 = pulse;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (edges >= TIMEOUT) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done after %0d edges, required done", edges);
    end
  endtask

  typedef struct {
    int          lat_extra;
    int          nf;
    int          fk0, fk1, fk2;
    logic [37:0] fm0, fm1, fm2;
    int          exp_ffi;    // -1: only the reference model decides
    bit          exp_pass;
  } row_t;

  row_t rows [5];

  initial begin
    logic [19:0] sa;
    logic [17:0] sb;
    logic [63:0] rnd;
    logic [37:0] e_ffz, prev;
    logic [19:0] prev_a;
    logic [17:0] prev_b;
    int          e_err, e_ffi, edges;

    reset  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;

    // Operand sequences straight from the LFSR definition
    sa = 20'h00001;
    sb = 18'h00001;
    for (int k = 0; k < N0; k++) begin
      ref_a[k] = sa;
      ref_b[k] = sb;
      ref_p[k] = 38'(sa) * 38'(sb);
      sa = {sa[18:0], sa[19] ^ sa[16]};
      sb = {sb[16:0], sb[17] ^ sb[10]};
    end

    rows[0] = '{0, 0, 0, 0, 0, 38'd0, 38'd0, 38'd0, 16'hFFFF, 1'b1};
    rows[1] = '{0, 1, 5, 0, 0, 38'd1, 38'd0, 38'd0, 5, 1'b0};
    rows[2] = '{1, 0, 0, 0, 0, 38'd0, 38'd0, 38'd0, 0, 1'b0};
    rows[3] = '{0, 1, N0 - 1, 0, 0, 38'h20_0000_0000, 38'd0, 38'd0, N0 - 1, 1'b0};
    rows[4] = '{0, 3, 0, 0, 0, 38'd0, 38'd0, 38'd0, -1, 1'b0};
    rows[4].fk0 = $urandom_range(0, N0 - 1);
    rows[4].fk1 = $urandom_range(0, N0 - 1);
    rows[4].fk2 = $urandom_range(0, N0 - 1);
    rnd = {$urandom, $urandom}; rows[4].fm0 = (rnd[37:0] == 0) ? 38'd1 : rnd[37:0];
    rnd = {$urandom, $urandom}; rows[4].fm1 = (rnd[37:0] == 0) ? 38'd2 : rnd[37:0];
    rnd = {$urandom, $urandom}; rows[4].fm2 = (rnd[37:0] == 0) ? 38'd4 : rnd[37:0];

    #22;
    check_reset0("reset");
    chk("reset_d1_a", a1, 0);
    chk("reset_d1_ffi", ffi1, 16'hFFFF);
    @(negedge clk);
    reset = 1'b1;
    prev_a = '0;
    prev_b = '0;

    // ---------- NUM_VECTORS=1, all-ones seeds ----------
    run(1'b1, 0, 0, edges);
    chk("d1_run_len", edges, 1 + 1 + LAT);
    chk("d1_a", a1, 20'hFFFFF);
    chk("d1_b", b1, 18'h3FFFF);
    chk("d1_pass", pass1, 1);
    chk("d1_err", err1, 0);
    m1_mask = 38'd1;
    run(1'b1, 0, 0, edges);
    chk("d1_fault_err", err1, 1);
    chk("d1_fault_ffi", ffi1, 0);
    chk("d1_fault_ffz", ffz1, 38'h3F_FFEC_0000);
    chk("d1_fault_pass", pass1, 0);
    m1_mask = '0;

    // ---------- table-driven full runs on dut0 ----------
    for (int r = 0; r < 5; r++) begin
      f_idx.delete();
      f_msk.delete();
      if (rows[r].nf > 0) begin f_idx.push_back(rows[r].fk0); f_msk.push_back(rows[r].fm0); end
      if (rows[r].nf > 1) begin f_idx.push_back(rows[r].fk1); f_msk.push_back(rows[r].fm1); end
      if (rows[r].nf > 2) begin f_idx.push_back(rows[r].fk2); f_msk.push_back(rows[r].fm2); end
      m0_lat = LAT + rows[r].lat_extra;
      prev = ({18'b0, prev_a} * {20'b0, prev_b}) ^ op_mask(prev_a, prev_b);
      predict(rows[r].lat_extra, prev, e_err, e_ffi, e_ffz);
      run(1'b0, 0, 0, edges);
      chk($sformatf("r%0d_run_len", r), edges, 1 + N0 + LAT);
      chk($sformatf("r%0d_err", r), err0, e_err);
      chk($sformatf("r%0d_ffi", r), ffi0, e_ffi);
      chk($sformatf("r%0d_ffz", r), ffz0, e_ffz);
      chk($sformatf("r%0d_pass_ref", r), pass0, (e_err == 0));
      chk($sformatf("r%0d_pass_tab", r), pass0, rows[r].exp_pass);
      if (rows[r].exp_ffi >= 0) chk($sformatf("r%0d_ffi_tab", r), ffi0, rows[r].exp_ffi);
      prev_a = ref_a[N0-1];
      prev_b = ref_b[N0-1];
    end
    m0_lat = LAT;

    // ---------- start pulses in RUN and DRAIN are ignored ----------
    f_idx.delete();
    f_msk.delete();
    f_idx.push_back(5);
    f_msk.push_back(38'd1);
    run(1'b0, 200, N0 + 2, edges);
    chk("ign_run_len", edges, 1 + N0 + LAT);
    chk("ign_err", err0, 1);
    chk("ign_ffi", ffi0, 5);
    chk("ign_ffz", ffz0, ref_p[5] | 38'd1);
    // start in DONE begins a new, clean run
    f_idx.delete();
    f_msk.delete();
    run(1'b0, 0, 0, edges);
    chk("rerun_len", edges, 1 + N0 + LAT);
    chk("rerun_pass", pass0, 1);
    chk("rerun_ffi", ffi0, 16'hFFFF);

    // ---------- reset mid-run, then replay from seeds ----------
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (101) @(posedge clk);
    @(negedge clk);
    chk("mid_a_idx100", a0, ref_a[100]);
    chk("mid_busy", busy0, 1);
    #2 reset = 1'b0;
    #1 check_reset0("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("replay_a%0d", k), a0, ref_a[k]);
      chk($sformatf("replay_b%0d", k), b0, ref_b[k]);
    end
    edges = 8;
    while (!done0 && edges < TIMEOUT) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("replay_run_len", edges, 1 + N0 + LAT);
    chk("replay_pass", pass0, 1);
    chk("replay_err", err0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
